// File: rtl/ifu.sv
// IFU: fetch PC register plus instruction register with branch / j / jr redirect and flush.
// Define IFU_ALIGN_CHECK_EN to suppress misaligned jr redirects and raise a sticky addr_err.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        out_ready,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_addr,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        addr_err
);

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic        instr_valid_r;
  logic        addr_err_r;

  logic        advance_s;
  logic        redirect_s;
  logic        jr_misaligned_s;
  logic [31:0] link_pc_s;
  logic [31:0] branch_off_s;
  logic [31:0] target_s;

  assign im_addr     = pc_r[11:2];
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign addr_err    = addr_err_r;

  // Redirect target selection and the advance / redirect decisions.
  always_comb begin
    link_pc_s    = instr_pc_r + 32'd4;
    branch_off_s = {{14{imm16[15]}}, imm16, 2'b00};
    target_s     = link_pc_s;
    case (npc_sel)
      2'b01:   target_s = link_pc_s + branch_off_s;
      2'b10:   target_s = {link_pc_s[31:28], target26, 2'b00};
      2'b11:   target_s = jr_addr & 32'hFFFF_FFFC;
      default: target_s = link_pc_s;
    endcase
`ifdef IFU_ALIGN_CHECK_EN
    jr_misaligned_s = (npc_sel == 2'b11) && (jr_addr[1:0] != 2'b00);
`else
    jr_misaligned_s = 1'b0;
`endif
    // A suppressed jr falls back to the ordinary fetch path.
    redirect_s = instr_valid_r && (npc_sel != 2'b00) && !jr_misaligned_s;
    advance_s  = !stall && (!instr_valid_r || out_ready);
  end

  // PC, instruction register and valid flag; redirects win over stall/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
    end else if (redirect_s) begin
      pc_r          <= target_s;
      instr_valid_r <= 1'b0;
    end else if (advance_s) begin
      pc_r          <= pc_r + 32'd4;
      instr_r       <= im_dout;
      instr_pc_r    <= pc_r;
      instr_valid_r <= 1'b1;
    end else begin
      pc_r          <= pc_r;
      instr_valid_r <= instr_valid_r;
    end
  end

  // Sticky misaligned-jr flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_r <= 1'b0;
    end else begin
`ifdef IFU_ALIGN_CHECK_EN
      addr_err_r <= addr_err_r | (instr_valid_r & jr_misaligned_s);
`else
      addr_err_r <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Table-driven bench for ifu with a behavioural instruction memory, plus hand-written
// sequences for misaligned jr and asynchronous reset during a redirect.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        out_ready;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] jr_addr;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        addr_err;

  logic [31:0] mem [0:1023];
  int n_applied = 0;
  int n_miscomp = 0;

  ifu dut (
    .clk(clk), .rst(rst), .stall(stall), .out_ready(out_ready), .npc_sel(npc_sel),
    .imm16(imm16), .target26(target26), .jr_addr(jr_addr), .im_addr(im_addr),
    .im_dout(im_dout), .pc(pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  assign im_dout = mem[im_addr];

  typedef struct packed {
    logic        stall;
    logic        rdy;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [25:0] t26;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_iv;
  } vec_t;

  vec_t vecs [0:26];

  function automatic vec_t mk(input logic s, input logic r, input logic [1:0] sel,
                              input logic [15:0] imm, input logic [25:0] t26,
                              input logic [31:0] jr, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_ipc,
                              input logic e_iv);
    vec_t v;
    v.stall = s; v.rdy = r; v.sel = sel; v.imm = imm; v.t26 = t26; v.jr = jr;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_iv = e_iv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_ipc, input logic e_iv, input logic e_err);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".im_addr"}, {22'd0, im_addr}, {22'd0, e_pc[11:2]});
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".instr_pc"}, instr_pc, e_ipc);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_iv});
    chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
  endtask

  task automatic drive(input logic s, input logic r, input logic [1:0] sel,
                       input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] jr);
    stall = s; out_ready = r; npc_sel = sel; imm16 = imm; target26 = t26; jr_addr = jr;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 + k;
    mem[0] = 32'h0000_0011; mem[1] = 32'h0000_0022;
    mem[2] = 32'h0000_0033; mem[3] = 32'h0000_0044;

    vecs[0]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_0011, 32'h0000_3000, 1'b1);
    vecs[1]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_0022, 32'h0000_3004, 1'b1);
    vecs[2]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_0033, 32'h0000_3008, 1'b1);
    vecs[3]  = mk(1'b1, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_0033, 32'h0000_3008, 1'b1);
    vecs[4]  = mk(1'b1, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_0033, 32'h0000_3008, 1'b1);
    vecs[5]  = mk(1'b1, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_0033, 32'h0000_3008, 1'b1);
    vecs[6]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 32'h0000_0044, 32'h0000_300C, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 32'h0000_0044, 32'h0000_300C, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 2'b01, 16'h0001, 26'h0, 32'h0, 32'h0000_3014, 32'h0000_0044, 32'h0000_300C, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3018, 32'hC0DE_0005, 32'h0000_3014, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 2'b11, 16'h0000, 26'h0, 32'h0000_3008, 32'h0000_3008, 32'hC0DE_0005, 32'h0000_3014, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_0033, 32'h0000_3008, 1'b1);
    vecs[12] = mk(1'b1, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_0033, 32'h0000_3008, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_0033, 32'h0000_3008, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_0022, 32'h0000_3004, 1'b1);
    vecs[15] = mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0000_3FFC, 32'h0000_3FFC, 32'h0000_0022, 32'h0000_3004, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_4000, 32'hC0DE_03FF, 32'h0000_3FFC, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 2'b10, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3040, 32'hC0DE_03FF, 32'h0000_3FFC, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3044, 32'hC0DE_0010, 32'h0000_3040, 1'b1);
    vecs[19] = mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC0DE_0010, 32'h0000_3040, 1'b0);
    vecs[20] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 32'hC0DE_03FF, 32'hFFFF_FFFC, 1'b1);
    vecs[21] = mk(1'b0, 1'b1, 2'b01, 16'h0002, 26'h0, 32'h0, 32'h0000_0008, 32'hC0DE_03FF, 32'hFFFF_FFFC, 1'b0);
    vecs[22] = mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0FFF_FFFC, 32'h0000_000C, 32'h0000_0033, 32'h0000_0008, 1'b1);
    vecs[23] = mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0FFF_FFFC, 32'h0FFF_FFFC, 32'h0000_0033, 32'h0000_0008, 1'b0);
    vecs[24] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h1000_0000, 32'hC0DE_03FF, 32'h0FFF_FFFC, 1'b1);
    vecs[25] = mk(1'b0, 1'b1, 2'b10, 16'h0000, 26'h0000004, 32'h0, 32'h1000_0010, 32'hC0DE_03FF, 32'h0FFF_FFFC, 1'b0);
    vecs[26] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h1000_0014, 32'hC0DE_0004, 32'h1000_0010, 1'b1);

    rst = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0);
    #12;
    chk_all("reset", 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("release", 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].stall, vecs[i].rdy, vecs[i].sel, vecs[i].imm, vecs[i].t26, vecs[i].jr);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_iv, 1'b0);
    end

    // Misaligned jr while a valid instruction sits in IR.
    drive(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0000_3006);
    @(posedge clk);
    #1;
`ifdef IFU_ALIGN_CHECK_EN
    chk_all("jr_mis", 32'h1000_0018, 32'hC0DE_0005, 32'h1000_0014, 1'b1, 1'b1);
`else
    chk_all("jr_mis", 32'h0000_3004, 32'hC0DE_0004, 32'h1000_0010, 1'b0, 1'b0);
`endif
    drive(1'b1, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0);
    @(posedge clk);
    #1;
`ifdef IFU_ALIGN_CHECK_EN
    chk("jr_mis.sticky", {31'd0, addr_err}, 32'd1);
`else
    chk("jr_mis.sticky", {31'd0, addr_err}, 32'd0);
`endif

    // Get a valid IR, then hit it with an async reset while a redirect is pending.
    drive(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_rst.valid", {31'd0, instr_valid}, 32'd1);
    drive(1'b1, 1'b1, 2'b01, 16'h0010, 26'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 16'h0000, 26'h0, 32'h0);
    #1;
    chk_all("rst_deassert", 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("first_fetch", 32'h0000_3004, 32'h0000_0011, 32'h0000_3000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard hold; freezes PC and IR.
REQ-005 out_ready  input  1  decode stage accepts instr this cycle.
REQ-006 npc_sel  input  2  redirect kind: 00 none, 01 branch, 10 j/jal, 11 jr/jalr.
REQ-007 imm16  input  16  branch offset, in words, of the instruction held in IR.
REQ-008 target26  input  26  jump index of the instruction held in IR.
REQ-009 jr_addr  input  32  register-sourced jump target.
REQ-010 im_addr  output  10  word address to instruction memory, bits [11:2] of PC.
REQ-011 im_dout  input  32  instruction word returned combinationally by instruction memory.
REQ-012 pc  output  32  current fetch PC.
REQ-013 instr  output  32  registered instruction (IR).
REQ-014 instr_pc  output  32  PC of the instruction in IR.
REQ-015 instr_valid  output  1  IR holds an instruction not yet consumed.
REQ-016 addr_err  output  1  sticky misaligned-jr flag.

Function
REQ-017 im_addr SHALL equal pc[11:2] combinationally; PC wraps modulo 2^32, and memory indexing wraps every 4 KB.
REQ-018 advance = !stall && (!instr_valid || out_ready); when advance=1 and npc_sel=00: instr<=im_dout, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
REQ-019 Latency: a word fetched at pc SHALL appear on instr one cycle after the advance edge.
REQ-020 When advance=0 and npc_sel=00, pc, instr, instr_pc and instr_valid SHALL hold; instr_valid=1 with out_ready=1 and stall=1 also holds.
REQ-021 A redirect (npc_sel!=00) SHALL only be acted on while instr_valid=1; it is ignored when instr_valid=0.
REQ-022 Branch target = instr_pc + 4 + {{14{imm16[15]}}, imm16, 2'b00}, in 32-bit wrapping arithmetic.
REQ-023 Jump target = {instr_pc[31:28] + carry of instr_pc+4 into bit 28, i.e. (instr_pc+4)[31:28], target26, 2'b00}.
REQ-024 jr target = jr_addr; see REQ-033/034 for bits [1:0].
REQ-025 An accepted redirect SHALL override stall and out_ready: pc<=target, instr_valid<=0 (flush of the wrong-path word), instr/instr_pc hold.
REQ-026 The redirect-consumed IR counts as accepted; no further handshake is required for it.
REQ-027 The first fetch after redirect SHALL follow REQ-018 from the target PC.

Reset
REQ-028 On rst=1, asynchronously: pc=RESET_PC, instr=32'h0, instr_pc=32'h0, instr_valid=0, addr_err=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first fetch after release is at RESET_PC.
REQ-030 No output SHALL change on the rst deassertion edge itself; the first advance occurs on the next rising clk edge.

Configuration
REQ-031 Macro IFU_ALIGN_CHECK_EN selects jr alignment checking.
REQ-032 All other behaviour SHALL be identical whether or not the macro is defined.
REQ-033 Defined, jr_addr[1:0]!=0: redirect suppressed (pc and IR follow REQ-018/020 as if npc_sel=00), and addr_err<=1, sticky until rst.
REQ-034 Undefined: jr target = {jr_addr[31:2], 2'b00}, and addr_err is tied 0.

Verification
REQ-035 Release rst; memory words 0..3 = 0x11,0x22,0x33,0x44; out_ready=1 -> im_addr 0,1,2,3 on successive cycles; instr 0x11 at 0x3000, then 0x22 at 0x3004.
REQ-036 Assert stall 3 cycles with instr_valid=1 -> pc, instr and instr_valid constant; resume -> next word with no loss or duplication.
REQ-037 IR instr_pc=0x3008, npc_sel=01, imm16=16'hFFFE -> next pc=0x3004 and instr_valid=0 for one cycle, even with stall=1.
REQ-038 instr_pc=0x3FFC, npc_sel=10, target26=26'h0000C10 -> pc=0x00003040; pc=0xFFFFFFFC advance -> pc=0x00000000, im_addr=0.
REQ-039 npc_sel=11, jr_addr=0x3006 -> with macro: pc unchanged path and addr_err=1 until rst; without macro: pc=0x3004 and addr_err=0.
REQ-040 Assert rst asynchronously between edges during a redirect -> outputs immediately take REQ-028 values; the first fetch after release is im_addr=0.
